sec_scan_disp: RTL

//  3-digit BCD seconds counter (000-999) with start/stop/clear control and a 7-segment scan driver.

---
 rtl/sec_scan_disp.sv | 115 +++++++++++
 1 files changed

// File: rtl/sec_scan_disp.sv
// sec_scan_disp: 3-digit BCD seconds counter with start/stop/clear FSM and registered 7-segment scan driver
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-low reset
//   tick     in   one-cycle 1 Hz count pulse
//   start    in   enter/resume counting
//   stop     in   pause counting
//   clear    in   zero count, return to IDLE
//   scan_sel in   digit select 0=ones 1=tens 2=hundreds, 3..7 = none
//   sec_bcd  out  {hundreds,tens,ones} BCD count
//   seg      out  segments {g,f,e,d,c,b,a}
//   com      out  digit commons, com[i] enables digit i
//   running  out  registered state==RUN
//   wrap     out  one-cycle pulse on 999->000 rollover
module sec_scan_disp #(
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit COM_ACT_LOW = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [2:0]  scan_sel,
    output logic [11:0] sec_bcd,
    output logic [6:0]  seg,
    output logic [2:0]  com,
    output logic        running,
    output logic        wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        running_q, running_d;
    logic        wrap_q, wrap_d;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  com_q, com_d;

    logic [3:0] ones, tens, hund, ones_n, tens_n, hund_n, dig;
    logic       inc, blank;
    logic [6:0] seg_hi;
    logic [2:0] com_hi;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        ones = cnt_q[3:0];
        tens = cnt_q[7:4];
        hund = cnt_q[11:8];
        state_d = state_q;
        if (clear)
            state_d = IDLE;
        else if (stop)
            state_d = (state_q == RUN) ? PAUSE : state_q;
        else if (start)
            state_d = RUN;
        // the count decision uses the current state, so a start-cycle tick is ignored
        inc = (state_q == RUN) && tick && !clear && !stop;
        ones_n = (ones == 4'd9) ? 4'd0 : ones + 4'd1;
        tens_n = (ones != 4'd9) ? tens : (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        hund_n = (ones != 4'd9 || tens != 4'd9) ? hund : (hund == 4'd9) ? 4'd0 : hund + 4'd1;
        cnt_d = clear ? 12'h000 : inc ? {hund_n, tens_n, ones_n} : cnt_q;
        wrap_d = inc && (cnt_q == 12'h999);
        running_d = (state_d == RUN);
        dig = (scan_sel == 3'd0) ? ones : (scan_sel == 3'd1) ? tens : hund;
        // a blanked digit keeps its common lit but shows no segments
        blank = BLANK_LZ && (((scan_sel == 3'd2) && (hund == 4'd0)) ||
                             ((scan_sel == 3'd1) && (hund == 4'd0) && (tens == 4'd0)));
        com_hi = (scan_sel == 3'd0) ? 3'b001 : (scan_sel == 3'd1) ? 3'b010 :
                 (scan_sel == 3'd2) ? 3'b100 : 3'b000;
        seg_hi = (scan_sel < 3'd3 && !blank) ? seg7(dig) : 7'b0000000;
        seg_d = SEG_ACT_LOW ? ~seg_hi : seg_hi;
        com_d = COM_ACT_LOW ? ~com_hi : com_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 12'h000;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            seg_q     <= SEG_ACT_LOW ? 7'h7F : 7'h00;
            com_q     <= COM_ACT_LOW ? 3'h7 : 3'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
            seg_q     <= seg_d;
            com_q     <= com_d;
        end
    end

    assign sec_bcd = cnt_q;
    assign seg     = seg_q;
    assign com     = com_q;
    assign running = running_q;
    assign wrap    = wrap_q;
endmodule
